// File: rtl/fft_pkg.sv
// Shared helpers for the FFT bit-reversal reorder buffer.
//   fft_addr_w  : address width (log2) for a power-of-two frame length
//   fft_bitrev  : reverses the low w bits of an index
//   FFT_ADDR_W  : address width for the default 16-point frame
package fft_pkg;

  localparam int unsigned FFT_N_POINTS_DEF = 16;

  // A 2-point frame still needs one address bit.
  function automatic int unsigned fft_addr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned FFT_ADDR_W = fft_addr_w(FFT_N_POINTS_DEF);

  // Bit-reverse the low w bits of idx; upper bits of the result are zero.
  function automatic logic [31:0] fft_bitrev(input logic [31:0] idx,
                                             input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) begin
        r[5'(w - 1 - i)] = idx[5'(i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One ping-pong bank: DEPTH x WIDTH storage, one write port, one
// asynchronous read port. All entries clear on reset.
//   clk_i, rst_ni   : clock, async active-low reset
//   we_i            : write enable
//   waddr_i/wdata_i : write address and data
//   raddr_i         : read address
//   rdata_c_o       : combinational read data
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int unsigned AW    = FFT_ADDR_W,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_c_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage with full clear on reset so a reset frame reads back as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders FFT output samples from bit-reversed to natural order using two
// ping-pong banks. Input sample k of a frame is written at bitrev(k); the
// read side walks addresses 0..N_POINTS-1 linearly.
//   clk, rst              : clock, async active-low reset
//   in_valid/in_ready     : input handshake; in_re/in_im sample parts
//   out_valid/out_ready   : output handshake; out_re/out_im sample parts
//   out_last              : marks the final sample of a frame
//   err                   : sticky overflow flag, present only when the
//                           FFT_REORDER_ERR_EN macro is defined
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N_POINTS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic                  out_last
`ifdef FFT_REORDER_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int unsigned AW = fft_addr_w(N_POINTS);
  localparam int unsigned SW = 2 * DATA_WIDTH;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);

  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;

  logic          accept_c;
  logic          xfer_c;
  logic [AW-1:0] wr_addr_c;
  logic [SW-1:0] wdata_c;
  logic [SW-1:0] rdata0_c, rdata1_c, rd_word_c;

  // Handshake decode straight from the bank flags.
  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign accept_c  = in_valid & in_ready;
  assign xfer_c    = out_valid & out_ready;
  assign out_last  = out_valid & (rd_idx_q == LAST_IDX);

  assign wr_addr_c = AW'(fft_bitrev(32'(wr_idx_q), AW));
  assign wdata_c   = {in_re, in_im};

  // Pointer, bank-select and full-flag next state. A bank being written is
  // never full and a bank being read always is, so the set and the clear
  // below always hit different flags and both survive the same edge.
  always_comb begin
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;

    if (accept_c) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d          = '0;
        wr_bank_d         = ~wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + AW'(1);
      end
    end

    if (xfer_c) begin
      if (rd_idx_q == LAST_IDX) begin
        rd_idx_d          = '0;
        rd_bank_d         = ~rd_bank_q;
        full_d[rd_bank_q] = 1'b0;
      end else begin
        rd_idx_d = rd_idx_q + AW'(1);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end

  fft_reorder_bank #(
    .AW    (AW),
    .DEPTH (N_POINTS),
    .WIDTH (SW)
  ) u_bank0 (
    .clk_i     (clk),
    .rst_ni    (rst),
    .we_i      (accept_c & ~wr_bank_q),
    .waddr_i   (wr_addr_c),
    .wdata_i   (wdata_c),
    .raddr_i   (rd_idx_q),
    .rdata_c_o (rdata0_c)
  );

  fft_reorder_bank #(
    .AW    (AW),
    .DEPTH (N_POINTS),
    .WIDTH (SW)
  ) u_bank1 (
    .clk_i     (clk),
    .rst_ni    (rst),
    .we_i      (accept_c & wr_bank_q),
    .waddr_i   (wr_addr_c),
    .wdata_i   (wdata_c),
    .raddr_i   (rd_idx_q),
    .rdata_c_o (rdata1_c)
  );

  assign rd_word_c = rd_bank_q ? rdata1_c : rdata0_c;
  assign out_re    = rd_word_c[SW-1:DATA_WIDTH];
  assign out_im    = rd_word_c[DATA_WIDTH-1:0];

`ifdef FFT_REORDER_ERR_EN
  logic err_q;

  // Sticky overflow: a sample offered while the write bank is still full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (in_valid && !in_ready) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder (N_POINTS=16, DATA_WIDTH=16).
module tb_fft_bitrev_reorder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_re;
  logic [15:0] in_im;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic        out_last;
`ifdef FFT_REORDER_ERR_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  fft_bitrev_reorder #(
    .DATA_WIDTH (16),
    .N_POINTS   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last)
`ifdef FFT_REORDER_ERR_EN
    ,
    .err       (err)
`endif
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          out_cnt = 0;
  int          in_cnt = 0;
  logic [31:0] exp_q[$];

  function automatic int br(input int i);
    logic [3:0] v;
    v = 4'(i);
    return 32'({v[0], v[1], v[2], v[3]});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Expected natural-order output of a frame whose input k carries base+bitrev(k).
  task automatic push_frame(input int base);
    for (int k = 0; k < 16; k++)
      exp_q.push_back({16'(base + k), 16'(100 + base + k)});
  endtask

  task automatic set_in(input int idx, input int base);
    in_valid = 1'b1;
    in_re    = 16'(base + br(idx));
    in_im    = 16'(100 + base + br(idx));
  endtask

  // One clock: score any output transfer and count any input acceptance
  // just before the edge, then settle 1 time unit past the edge.
  task automatic step();
    logic [31:0] e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", 32'(out_cnt), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_re", 32'(out_re), 32'(e[31:16]));
        check("out_im", 32'(out_im), 32'(e[15:0]));
        check("out_last", 32'(out_last), 32'((out_cnt % 16) == 15));
      end
      out_cnt++;
    end
    if (in_valid && in_ready) in_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int target);
    int guard;
    guard = 0;
    while (out_cnt < target && guard < 200) begin
      step();
      guard++;
    end
    check("drain_count", 32'(out_cnt), 32'(target));
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    out_cnt  = 0;
    in_cnt   = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    logic        snap_last;
    int          c;

    // Reset state.
    rst = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_re",    32'(out_re),    32'd0);
    check("rst_out_im",    32'(out_im),    32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef FFT_REORDER_ERR_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single frame with latency check.
    out_ready = 1'b1;
    push_frame(0);
    for (int i = 0; i < 16; i++) begin
      set_in(i, 0);
      if (i == 15) check("single_pre_valid", 32'(out_valid), 32'd0);
      step();
    end
    in_valid = 1'b0;
    check("single_valid_lat", 32'(out_valid), 32'd1);
    drain(16);
    check("single_idle", 32'(out_valid), 32'd0);

    // Backpressure: 40 offered, 32 fit.
    do_reset();
    out_ready = 1'b0;
    for (int s = 0; s < 40; s++) begin
      set_in(s % 16, 16'h200 + 16'h100 * (s / 16));
      step();
      if (s == 30) check("bp_ready_before", 32'(in_ready), 32'd1);
      if (s == 31) check("bp_ready_after",  32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(in_cnt), 32'd32);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    push_frame(16'h200);
    push_frame(16'h300);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 14) check("bp_free_before", 32'(in_ready), 32'd0);
      if (k == 15) check("bp_free_after",  32'(in_ready), 32'd1);
    end
    drain(32);
    check("bp_idle", 32'(out_valid), 32'd0);

    // Continuous streaming, 4 frames.
    do_reset();
    out_ready = 1'b1;
    for (int s = 0; s < 64; s++) begin
      if (s % 16 == 0) push_frame(16'h1000 + 16 * (s / 16));
      set_in(s % 16, 16'h1000 + 16 * (s / 16));
      if (s >= 16) check("stream_gap", 32'(out_valid), 32'd1);
      step();
      check("stream_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("stream_tail_gap", 32'(out_valid), 32'd1);
      step();
    end
    check("stream_count", 32'(out_cnt), 32'd64);
    check("stream_idle", 32'(out_valid), 32'd0);

    // Output stall with toggling ready.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_in(i, 16'h600);
      step();
    end
    in_valid = 1'b0;
    push_frame(16'h600);
    c = 0;
    while (out_cnt < 16 && c < 100) begin
      out_ready = (c < 3) || (c % 2 == 0) || (c > 40);
      if (!out_ready && out_valid) begin
        snap      = {out_re, out_im};
        snap_last = out_last;
        step();
        check("stall_hold_data", {out_re, out_im}, snap);
        check("stall_hold_last", 32'(out_last), 32'(snap_last));
      end else begin
        step();
      end
      c++;
    end
    check("stall_count", 32'(out_cnt), 32'd16);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation: one full unread frame plus 7 partial inputs.
    do_reset();
    out_ready = 1'b0;
    for (int s = 0; s < 23; s++) begin
      set_in(s % 16, 16'h700);
      step();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_re",    32'(out_re),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    out_cnt = 0;
    in_cnt  = 0;
    out_ready = 1'b1;
    push_frame(16'h800);
    for (int i = 0; i < 16; i++) begin
      set_in(i, 16'h800);
      step();
    end
    in_valid = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd1);
    drain(16);
    check("midrst_idle", 32'(out_valid), 32'd0);

`ifdef FFT_REORDER_ERR_EN
    // Overflow flag with both banks full.
    do_reset();
    out_ready = 1'b0;
    for (int s = 0; s < 32; s++) begin
      set_in(s % 16, 16'h900 + 16'h100 * (s / 16));
      step();
    end
    check("err_clear", 32'(err), 32'd0);
    in_valid = 1'b1; in_re = 16'hDEAD; in_im = 16'hBEEF;
    step();
    in_valid = 1'b0;
    check("err_set", 32'(err), 32'd1);
    repeat (3) step();
    check("err_sticky", 32'(err), 32'd1);
    push_frame(16'h900);
    push_frame(16'hA00);
    out_ready = 1'b1;
    drain(32);
    check("err_after_drain", 32'(err), 32'd1);
    do_reset();
    check("err_reset", 32'(err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
